// File: rtl/led_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : led_pulse_stretcher
// Purpose  : Stretches short internal events into visible LED blinks (fixed
//            ON time, fixed OFF gap); events arriving mid-blink are queued.
// Revision : 1.0  initial release
// ============================================================================
module led_pulse_stretcher #(
    parameter logic        ACTIVE_LEVEL = 1'b1,
    parameter logic [18:0] CNT_ON       = 19'h3D090,
    parameter logic [18:0] CNT_OFF      = 19'h3D090,
    parameter int          PEND_W       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_event,
    output logic              o_led,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_drop
);

    localparam logic [PEND_W-1:0] c_MAX_PEND = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t            r_state;
    logic [18:0]       r_cnt;
    logic [PEND_W-1:0] r_pend;
    logic              r_event_q;
    logic              r_led;
    logic              r_drop;

    logic w_ev;
    logic w_off_done;
    logic w_start_ev;
    logic w_start_pend;
    logic w_inc;
    logic w_dec;

    assign w_ev       = i_event & ~r_event_q;
    assign w_off_done = (r_state == ST_OFF) && (r_cnt == CNT_OFF);

    // A blink may only start from IDLE or at the end of an OFF gap; queued
    // events take priority over a fresh one at the end of a gap.
    always_comb begin
        w_start_ev   = 1'b0;
        w_start_pend = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ev)
                    w_start_ev = 1'b1;
                else if (r_pend != '0)
                    w_start_pend = 1'b1;
            end
            ST_OFF: begin
                if (w_off_done) begin
                    if (r_pend != '0)
                        w_start_pend = 1'b1;
                    else if (w_ev)
                        w_start_ev = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_inc = w_ev & ~w_start_ev;
    assign w_dec = w_start_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend    <= '0;
            r_event_q <= 1'b0;
            r_led     <= ~ACTIVE_LEVEL;
            r_drop    <= 1'b0;
        end else begin
            r_event_q <= i_event;
            r_drop    <= 1'b0;

            if (w_inc && !w_dec) begin
                if (r_pend == c_MAX_PEND)
                    r_drop <= 1'b1;
                else
                    r_pend <= r_pend + 1'b1;
            end else if (w_dec && !w_inc) begin
                r_pend <= r_pend - 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_start_ev || w_start_pend) begin
                        r_state <= ST_ON;
                        r_led   <= ACTIVE_LEVEL;
                    end else begin
                        r_led   <= ~ACTIVE_LEVEL;
                    end
                end
                ST_ON: begin
                    if (r_cnt == CNT_ON) begin
                        r_state <= ST_OFF;
                        r_cnt   <= '0;
                        r_led   <= ~ACTIVE_LEVEL;
                    end else begin
                        r_cnt   <= r_cnt + 19'd1;
                    end
                end
                ST_OFF: begin
                    if (w_off_done) begin
                        r_cnt <= '0;
                        if (w_start_ev || w_start_pend) begin
                            r_state <= ST_ON;
                            r_led   <= ACTIVE_LEVEL;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 19'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_led   <= ~ACTIVE_LEVEL;
                end
            endcase
        end
    end

    assign o_led     = r_led;
    assign o_busy    = (r_state != ST_IDLE) || (r_pend != '0);
    assign o_pending = r_pend;
    assign o_drop    = r_drop;

endmodule
`default_nettype wire

// File: doc/led_pulse_stretcher.md
Name: led_pulse_stretcher

Overview:
- Output-side companion to the button debouncer.
- The debouncer rejects short pulses arriving from a physical input. This block extends short internal events (1-cycle strobes or levels) into human-visible blinks on a physical output pin (LED).
- Each accepted event produces one blink: fixed ON time, then fixed OFF gap.
- Events arriving during a blink are queued in a saturating pending counter and replayed back-to-back.

Parameters:
- ACTIVE_LEVEL, 1'b1, pin level that means LED on; idle level is ~ACTIVE_LEVEL.
- CNT_ON, 19'h3D090, ON phase terminal count; ON lasts CNT_ON+1 clk cycles. Must be >= 1.
- CNT_OFF, 19'h3D090, OFF gap terminal count; OFF lasts CNT_OFF+1 clk cycles. Must be >= 1.
- PEND_W, 3, pending counter width; MAX_PEND = 2**PEND_W-1.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- i_event  input  1  event request, synchronous to clk; rising edge = one event.
- o_led  output  1  registered LED drive.
- o_busy  output  1  high while a blink is in progress or events are pending.
- o_pending  output  PEND_W  current pending event count.
- o_drop  output  1  one-cycle strobe when an event is lost to saturation.

Behaviour:
- Reset (async, rst_n=0) forces all of the following immediately, including mid-blink:
  - state=IDLE, counter=0, pending=0, edge register=0.
  - o_led=~ACTIVE_LEVEL, o_drop=0.
- Edge detect:
  - ev = i_event & ~i_event_q, where i_event_q is i_event registered each cycle.
  - A held level counts once; re-arms only after i_event returns to 0.
- Counter: 19-bit, cleared on every state entry, increments by 1 each cycle in ON/OFF, never wraps (a terminal compare always exits the state first).
- States:
  - IDLE:
    - o_led=~ACTIVE_LEVEL.
    - If ev -> ON; the event is consumed directly, pending unchanged.
    - Else if pending>0 -> ON; pending decrements.
  - ON:
    - o_led=ACTIVE_LEVEL.
    - When counter==CNT_ON -> OFF.
  - OFF:
    - o_led=~ACTIVE_LEVEL.
    - When counter==CNT_OFF:
      - If pending>0 -> ON; pending decrements.
      - Else if ev -> ON; ev consumed directly.
      - Else -> IDLE.
- Latency: ev sampled at posedge N gives o_led=ACTIVE_LEVEL after posedge N (state ON from edge N). Single isolated event: ON CNT_ON+1 cycles, then OFF CNT_OFF+1 cycles, then IDLE.
- Pending update each cycle: next = pending + inc - dec.
  - inc: ev and ev not consumed directly.
  - dec: a blink starts from pending.
  - Increment and decrement in the same cycle leave the count unchanged and never drop.
  - Saturation: inc while pending==MAX_PEND with no dec -> pending stays MAX_PEND, o_drop=1 for that cycle.
- o_busy = (state!=IDLE) | (pending!=0). Combinational from registers.
- o_pending mirrors the pending register.
- An OFF gap is always inserted between consecutive blinks, so back-to-back blinks stay distinguishable.

Test Plan:
Common params: CNT_ON=4, CNT_OFF=2, PEND_W=2, ACTIVE_LEVEL=1.
- Reset: rst_n=0 with i_event toggling -> o_led=0, o_busy=0, o_pending=0, o_drop=0. After release with i_event=0 -> stays idle indefinitely.
- Single pulse: i_event=1 for one cycle, sampled at edge 10 -> o_led=1 after edges 10..14 (5 cycles), 0 after edges 15..17 (3 cycles). o_busy=0 after edge 18.
- Held level: i_event=1 for 40 cycles -> exactly one blink, o_pending stays 0. A second rising edge after a drop to 0 -> a second blink.
- Queueing: 3 separated pulses during the first ON phase -> o_pending climbs 1,2,3. Then 4 blinks total, each 5 on / 3 off, o_pending decrementing at each blink start. No o_drop.
- Saturation: 5 pulses during the first blink -> o_pending saturates at 3, o_drop pulses exactly twice, 4 blinks total.
- Boundaries:
  - Pulse on the OFF terminal cycle with pending=0 -> next blink starts with no IDLE cycle.
  - rst_n low mid-ON -> o_led=0 immediately, o_pending=0.
  - ACTIVE_LEVEL=0 rerun of the single-pulse case -> inverted o_led waveform, idle level 1.
